// File: rtl/rf_2p_banked_pm.sv
// Banked two-port register file: valid/ready handshakes, same-address bypass,
// and per-bank idle-driven retention with a timed wake-up, over rf_2p_hse macros.

module rf_2p_hse #(
    parameter int BITS       = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLKA,
    input  logic                  CENA,
    input  logic [ADDR_WIDTH-1:0] AA,
    output logic [BITS-1:0]       QA,
    input  logic                  CLKB,
    input  logic                  CENB,
    input  logic [ADDR_WIDTH-1:0] AB,
    input  logic [BITS-1:0]       DB,
    input  logic [2:0]            EMAA,
    input  logic [2:0]            EMAB,
    input  logic [1:0]            EMAWB,
    input  logic                  EMASA,
    input  logic                  TENA,
    input  logic                  TCENA,
    input  logic [ADDR_WIDTH-1:0] TAA,
    input  logic                  TENB,
    input  logic                  TCENB,
    input  logic [ADDR_WIDTH-1:0] TAB,
    input  logic [BITS-1:0]       TDB,
    input  logic                  BENA,
    input  logic [BITS-1:0]       TQA,
    input  logic                  STOVA,
    input  logic                  STOVB,
    input  logic                  COLLDISN,
    input  logic                  RET1N
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [BITS-1:0]       mem [DEPTH];
    logic [BITS-1:0]       q;
    logic                  cen_a, cen_b;
    logic [ADDR_WIDTH-1:0] a_a, a_b;
    logic [BITS-1:0]       d_b;
    logic                  collide, margin_ok;

    assign cen_a = TENA ? CENA : TCENA;
    assign a_a   = TENA ? AA   : TAA;
    assign cen_b = TENB ? CENB : TCENB;
    assign a_b   = TENB ? AB   : TAB;
    assign d_b   = TENB ? DB   : TDB;

    // Margin settings outside the characterised window, and detected
    // same-address collisions, return zeros instead of array data.
    assign margin_ok = (EMAA != 3'b000) && (EMAB != 3'b000) && (EMAWB != 2'b11)
                       && !EMASA && !STOVA && !STOVB;
    assign collide   = COLLDISN && !cen_a && !cen_b && (a_a == a_b);

    always_ff @(posedge CLKA) begin
        if (RET1N && !cen_a) begin
            q <= (collide || !margin_ok) ? '0 : mem[a_a];
        end
    end

    always_ff @(posedge CLKB) begin
        if (RET1N && !cen_b) begin
            mem[a_b] <= d_b;
        end
    end

    assign QA = BENA ? q : TQA;
endmodule

module rf_2p_banked_pm #(
    parameter int         DATA_W      = 32,
    parameter int         BANK_BITS   = 1,
    parameter int         ADDR_WIDTH  = 8,
    parameter int         ADDR_W      = ADDR_WIDTH + BANK_BITS,
    parameter int         IDLE_CYCLES = 64,
    parameter int         WAKE_CYCLES = 2,
    parameter logic [2:0] EMAA_V      = 3'b010,
    parameter logic [2:0] EMAB_V      = 3'b010,
    parameter logic [1:0] EMAWB_V     = 2'b00,
    parameter logic       EMASA_V     = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_ready,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          wr_req,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          sleep_en,
    output logic [(2**BANK_BITS)-1:0]     bank_sleep
);
    localparam int          MACRO_BITS = 32;
    localparam int unsigned NB = 2 ** BANK_BITS;
    localparam int          BW = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int          IW = $clog2(IDLE_CYCLES);
    localparam int          WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_MAX = WW'(WAKE_CYCLES - 1);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_SLEEP  = 2'd1;
    localparam logic [1:0] ST_WAKE   = 2'd2;

    if (DATA_W != MACRO_BITS) begin : g_bad_width
        $error("rf_2p_banked_pm: DATA_W (%0d) must equal macro BITS (%0d)", DATA_W, MACRO_BITS);
    end
    if (BANK_BITS < 0 || BANK_BITS > 3) begin : g_bad_banks
        $error("rf_2p_banked_pm: BANK_BITS (%0d) out of range 0..3", BANK_BITS);
    end
    if (IDLE_CYCLES < 2 || WAKE_CYCLES < 1) begin : g_bad_timing
        $error("rf_2p_banked_pm: IDLE_CYCLES must be >= 2 and WAKE_CYCLES >= 1");
    end

    logic [BW-1:0]     rd_bank, wr_bank;
    logic [NB-1:0]     rd_hit, wr_hit, bank_active, bank_req, bank_acc;
    logic              rd_acc, wr_acc;
    logic [DATA_W-1:0] qa [NB];

    if (BANK_BITS > 0) begin : g_bank_sel
        assign rd_bank = rd_addr[ADDR_W-1 -: BW];
        assign wr_bank = wr_addr[ADDR_W-1 -: BW];
    end else begin : g_single_bank
        assign rd_bank = '0;
        assign wr_bank = '0;
    end

    assign rd_ready = |(rd_hit & bank_active);
    assign wr_ready = |(wr_hit & bank_active);
    assign rd_acc   = rd_req & rd_ready;
    assign wr_acc   = wr_req & wr_ready;
    assign bank_req = (rd_hit & {NB{rd_req}}) | (wr_hit & {NB{wr_req}});
    assign bank_acc = (rd_hit & {NB{rd_acc}}) | (wr_hit & {NB{wr_acc}});

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [1:0]    state;
        logic [IW-1:0] idle_cnt;
        logic [WW-1:0] wake_cnt;
        logic          cena, cenb, ret1n;

        assign rd_hit[b] = (rd_bank == BW'(b));
        assign wr_hit[b] = (wr_bank == BW'(b));

        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= ST_ACTIVE;
                idle_cnt <= '0;
                wake_cnt <= '0;
            end else begin
                case (state)
                    ST_ACTIVE: begin
                        wake_cnt <= '0;
                        // A request in the expiry cycle keeps the bank awake.
                        if (sleep_en && idle_cnt == IDLE_MAX && !bank_req[b]) begin
                            state    <= ST_SLEEP;
                            idle_cnt <= '0;
                        end else if (bank_acc[b]) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt != IDLE_MAX) begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
                    ST_SLEEP: begin
                        idle_cnt <= '0;
                        if (bank_req[b] || !sleep_en) begin
                            state    <= ST_WAKE;
                            wake_cnt <= '0;
                        end
                    end
                    ST_WAKE: begin
                        idle_cnt <= '0;
                        if (wake_cnt == WAKE_MAX) begin
                            state <= ST_ACTIVE;
                        end else begin
                            wake_cnt <= wake_cnt + WW'(1);
                        end
                    end
                    default: begin
                        state    <= ST_ACTIVE;
                        idle_cnt <= '0;
                        wake_cnt <= '0;
                    end
                endcase
            end
        end

        assign bank_active[b] = (state == ST_ACTIVE);
        assign bank_sleep[b]  = (state == ST_SLEEP);
        assign ret1n          = (state != ST_SLEEP);
        assign cena           = ~(rd_acc & rd_hit[b]);
        assign cenb           = ~(wr_acc & wr_hit[b]);

        rf_2p_hse #(
            .BITS       (DATA_W),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_macro (
            .CLKA     (clk),
            .CENA     (cena),
            .AA       (rd_addr[ADDR_WIDTH-1:0]),
            .QA       (qa[b]),
            .CLKB     (clk),
            .CENB     (cenb),
            .AB       (wr_addr[ADDR_WIDTH-1:0]),
            .DB       (wr_data),
            .EMAA     (EMAA_V),
            .EMAB     (EMAB_V),
            .EMAWB    (EMAWB_V),
            .EMASA    (EMASA_V),
            .TENA     (1'b1),
            .TCENA    (1'b0),
            .TAA      ('0),
            .TENB     (1'b1),
            .TCENB    (1'b0),
            .TAB      ('0),
            .TDB      ('0),
            .BENA     (1'b1),
            .TQA      ('0),
            .STOVA    (1'b0),
            .STOVB    (1'b0),
            .COLLDISN (1'b1),
            .RET1N    (ret1n)
        );
    end

    logic [NB-1:0]     rd_sel_q;
    logic              byp_q;
    logic [DATA_W-1:0] byp_data_q, hold_q, qa_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            rd_sel_q   <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            hold_q     <= '0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_sel_q <= rd_hit;
                byp_q    <= wr_acc && (wr_addr == rd_addr);
            end
            if (rd_acc && wr_acc && (wr_addr == rd_addr)) begin
                byp_data_q <= wr_data;
            end
            if (rd_valid) begin
                hold_q <= rd_data;
            end
        end
    end

    always_comb begin
        qa_sel = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (rd_sel_q[b]) begin
                qa_sel = qa[b];
            end
        end
    end

    // Output is held between reads so it never follows macro QA while idle.
    assign rd_data = rd_valid ? (byp_q ? byp_data_q : qa_sel) : hold_q;
endmodule

// File: tb/tb_rf_2p_banked_pm.sv
// Self-checking bench for rf_2p_banked_pm: directed vector table, multi-cycle
// power-management sequences, and randomized traffic against a timestamp model.

module tb_rf_2p_banked_pm;
    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int IDLE = 64;
    localparam int WAKE = 2;
    localparam int NB   = 2;

    logic          clk = 1'b0;
    logic          rst, rd_req, wr_req, sleep_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic          rd_ready, wr_ready, rd_valid;
    logic [NB-1:0] bank_sleep;

    always #5 clk = ~clk;

    rf_2p_banked_pm #(
        .DATA_W      (DW),
        .BANK_BITS   (1),
        .ADDR_WIDTH  (8),
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .sleep_en   (sleep_en),
        .bank_sleep (bank_sleep)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: banks tracked by mode plus cycle timestamps.
    typedef enum {M_ACT, M_SLP, M_WAK} mode_t;
    mode_t       m_mode [NB];
    int          m_ref [NB];
    int          m_act_at [NB];
    int          cyc = 0;
    logic [31:0] m_mem [512];
    bit          m_known [512];
    bit          e_valid = 0;
    logic [31:0] e_data = '0;
    bit          e_known = 1;
    bit          model_check = 0;

    logic          s_rdy, s_wdy, s_valid;
    logic [31:0]   s_data;
    logic [NB-1:0] s_sleep;

    typedef struct {
        bit          rd;
        logic [8:0]  ra;
        bit          wr;
        logic [8:0]  wa;
        logic [31:0] wd;
        bit          x_valid;
        logic [31:0] x_data;
    } vec_t;
    vec_t tbl [9];

    function automatic int bank_of(logic [AW-1:0] a);
        return int'(a[AW-1]);
    endfunction

    function automatic logic [AW-1:0] pick(int m);
        int bk;
        bk = (m == 3) ? int'($urandom_range(0, 1)) : ((m == 2) ? 1 : 0);
        return AW'(bk * 256 + int'($urandom_range(0, 15)));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_settle();
        for (int b = 0; b < NB; b++) begin
            if (m_mode[b] == M_WAK && cyc >= m_act_at[b]) begin
                m_mode[b] = M_ACT;
                m_ref[b]  = m_act_at[b];
            end
        end
    endtask

    task automatic model_step();
        bit ra, wa, req, acc;
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                if (m_mode[b] != M_ACT) begin
                    for (int a = 0; a < 512; a++) if (bank_of(AW'(a)) == b) m_known[a] = 0;
                end
                m_mode[b] = M_ACT;
                m_ref[b]  = cyc + 1;
            end
            e_valid = 0;
            e_data  = '0;
            e_known = 1;
        end else begin
            ra = rd_req && (m_mode[bank_of(rd_addr)] == M_ACT);
            wa = wr_req && (m_mode[bank_of(wr_addr)] == M_ACT);
            e_valid = ra;
            if (ra) begin
                if (wa && rd_addr == wr_addr) begin
                    e_data  = wr_data;
                    e_known = 1;
                end else begin
                    e_data  = m_mem[rd_addr];
                    e_known = m_known[rd_addr];
                end
            end
            if (wa) begin
                m_mem[wr_addr]   = wr_data;
                m_known[wr_addr] = 1;
            end
            for (int b = 0; b < NB; b++) begin
                req = (rd_req && bank_of(rd_addr) == b) || (wr_req && bank_of(wr_addr) == b);
                acc = (ra && bank_of(rd_addr) == b) || (wa && bank_of(wr_addr) == b);
                case (m_mode[b])
                    M_ACT: begin
                        if (sleep_en && (cyc - m_ref[b] >= IDLE - 1) && !req) m_mode[b] = M_SLP;
                        else if (acc) m_ref[b] = cyc + 1;
                    end
                    M_SLP: begin
                        if (req || !sleep_en) begin
                            m_mode[b]   = M_WAK;
                            m_act_at[b] = cyc + 1 + WAKE;
                        end
                    end
                    default: ;
                endcase
            end
        end
        cyc++;
    endtask

    task automatic tick();
        logic [1:0] xs;
        @(negedge clk);
        model_settle();
        s_rdy   = rd_ready;
        s_wdy   = wr_ready;
        s_valid = rd_valid;
        s_data  = rd_data;
        s_sleep = bank_sleep;
        if (model_check) begin
            xs = {m_mode[1] == M_SLP, m_mode[0] == M_SLP};
            check("rnd_rd_ready", 32'(s_rdy), 32'(m_mode[bank_of(rd_addr)] == M_ACT));
            check("rnd_wr_ready", 32'(s_wdy), 32'(m_mode[bank_of(wr_addr)] == M_ACT));
            check("rnd_bank_sleep", 32'(s_sleep), 32'(xs));
            check("rnd_rd_valid", 32'(s_valid), 32'(e_valid));
            if (e_known) check("rnd_rd_data", s_data, e_data);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    initial begin
        int k;
        int mask, rate;

        for (int b = 0; b < NB; b++) begin
            m_mode[b] = M_ACT; m_ref[b] = 0; m_act_at[b] = 0;
        end
        for (int a = 0; a < 512; a++) begin
            m_mem[a] = '0; m_known[a] = 0;
        end
        rst = 1; rd_req = 0; wr_req = 0; sleep_en = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;

        tbl[0] = '{0, 9'h000, 1, 9'h005, 32'hDEADBEEF, 0, 32'h0};
        tbl[1] = '{1, 9'h005, 1, 9'h010, 32'h0A0A0A0A, 0, 32'h0};
        tbl[2] = '{0, 9'h005, 1, 9'h0A3, 32'h00000000, 1, 32'hDEADBEEF};
        tbl[3] = '{1, 9'h0A3, 1, 9'h0A3, 32'h12345678, 0, 32'hDEADBEEF};
        tbl[4] = '{1, 9'h0A3, 0, 9'h0A3, 32'h0,        1, 32'h12345678};
        tbl[5] = '{1, 9'h010, 1, 9'h105, 32'hCAFEF00D, 1, 32'h12345678};
        tbl[6] = '{1, 9'h105, 0, 9'h105, 32'h0,        1, 32'h0A0A0A0A};
        tbl[7] = '{0, 9'h105, 0, 9'h105, 32'h0,        1, 32'hCAFEF00D};
        tbl[8] = '{0, 9'h105, 0, 9'h105, 32'h0,        0, 32'hCAFEF00D};

        repeat (3) tick();
        rst = 0;

        // Directed table, sleep disabled; entry 0 also covers the reset state.
        for (int i = 0; i < 9; i++) begin
            rd_req = tbl[i].rd; rd_addr = tbl[i].ra;
            wr_req = tbl[i].wr; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            tick();
            check($sformatf("tbl%0d_rd_valid", i), 32'(s_valid), 32'(tbl[i].x_valid));
            check($sformatf("tbl%0d_rd_data", i), s_data, tbl[i].x_data);
            check($sformatf("tbl%0d_readies", i), {30'b0, s_rdy, s_wdy}, 32'h3);
            check($sformatf("tbl%0d_bank_sleep", i), 32'(s_sleep), 32'h0);
        end

        // Read in flight at reset is dropped; then idle entry into retention.
        rst = 1; rd_req = 1; rd_addr = 9'h005; wr_req = 0;
        tick();
        rst = 0; rd_req = 0; sleep_en = 1;
        tick();
        check("rst_drop_rd_valid", 32'(s_valid), 32'h0);
        for (int c = 1; c <= 63; c++) tick();
        check("idle63_bank_sleep", 32'(s_sleep), 32'h0);
        tick();
        check("idle64_bank_sleep", 32'(s_sleep), 32'h3);
        repeat (2) tick();

        rd_req = 1; rd_addr = 9'h105;
        tick();
        check("wake_n_rd_ready", 32'(s_rdy), 32'h0);
        check("wake_n_bank_sleep", 32'(s_sleep), 32'h3);
        tick();
        check("wake_n1_rd_ready", 32'(s_rdy), 32'h0);
        check("wake_n1_bank_sleep", 32'(s_sleep), 32'h1);
        tick();
        check("wake_n2_rd_ready", 32'(s_rdy), 32'h0);
        tick();
        check("wake_n3_rd_ready", 32'(s_rdy), 32'h1);
        rd_req = 0;
        tick();
        check("wake_rd_valid", 32'(s_valid), 32'h1);
        check("wake_rd_data_retained", s_data, 32'hCAFEF00D);

        // Write in the idle-expiry cycle of bank 0 keeps it awake and restarts the count.
        rst = 1;
        tick();
        rst = 0;
        for (int c = 0; c <= 62; c++) tick();
        wr_req = 1; wr_addr = 9'h007; wr_data = 32'h600DCAFE;
        tick();
        check("expiry_wr_ready", 32'(s_wdy), 32'h1);
        wr_req = 0;
        tick();
        check("expiry64_bank_sleep", 32'(s_sleep), 32'h2);
        for (int c = 65; c <= 127; c++) tick();
        check("expiry127_bank_sleep", 32'(s_sleep), 32'h2);
        tick();
        check("expiry128_bank_sleep", 32'(s_sleep), 32'h3);

        rd_req = 1; rd_addr = 9'h007;
        k = 0;
        while (k < 10) begin
            tick();
            if (s_rdy) break;
            k++;
        end
        check("wake0_accept_delay", 32'(k), 32'(WAKE + 1));
        rd_req = 0;
        tick();
        check("wake0_rd_valid", 32'(s_valid), 32'h1);
        check("wake0_rd_data", s_data, 32'h600DCAFE);

        // Reset while bank 1 is in WAKE.
        rd_req = 1; rd_addr = 9'h105;
        tick();
        check("wrst_n_rd_ready", 32'(s_rdy), 32'h0);
        rst = 1;
        tick();
        check("wrst_n1_bank1_waking", 32'(s_sleep[1]), 32'h0);
        rst = 0; rd_req = 0;
        tick();
        check("wrst_bank_sleep", 32'(s_sleep), 32'h0);
        check("wrst_readies", {30'b0, s_rdy, s_wdy}, 32'h3);
        check("wrst_rd_valid", 32'(s_valid), 32'h0);

        // Randomized traffic in phases with varying bank focus, rate and sleep enable.
        rst = 1;
        tick();
        rst = 0;
        model_check = 1;
        for (int ph = 0; ph < 12; ph++) begin
            mask     = int'($urandom_range(1, 3));
            rate     = int'($urandom_range(0, 50));
            sleep_en = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 250; c++) begin
                if (!rd_req && int'($urandom_range(0, 99)) < rate) begin
                    rd_req  = 1;
                    rd_addr = pick(mask);
                end
                if (!wr_req && int'($urandom_range(0, 99)) < rate) begin
                    wr_req  = 1;
                    wr_addr = (rd_req && $urandom_range(0, 3) == 0) ? rd_addr : pick(mask);
                    wr_data = $urandom;
                end
                tick();
                if (rd_req && s_rdy) rd_req = 0;
                if (wr_req && s_wdy) wr_req = 0;
            end
        end
        model_check = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
